multicycle_ctrl: RTL and testbench



---
 rtl/multicycle_pkg.sv | 54 +++++
 rtl/multicycle_out_decode.sv | 62 ++++++
 rtl/multicycle_ctrl.sv | 95 +++++++++
 tb/tb_multicycle_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle RV32 control FSM: states, opcodes,
// ALUOp and datapath select codes, plus the decoded control word.
package multicycle_pkg;

   localparam logic [3:0] S_FETCH     = 4'd0;
   localparam logic [3:0] S_DECODE    = 4'd1;
   localparam logic [3:0] S_MEM_ADDR  = 4'd2;
   localparam logic [3:0] S_MEM_READ  = 4'd3;
   localparam logic [3:0] S_MEM_WB    = 4'd4;
   localparam logic [3:0] S_MEM_WRITE = 4'd5;
   localparam logic [3:0] S_EXEC_R    = 4'd6;
   localparam logic [3:0] S_ALU_WB    = 4'd7;
   localparam logic [3:0] S_BRANCH    = 4'd8;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   // fetch/branch flag the states whose pc_write/ir_write get gated at the top
   typedef struct packed {
      logic       mem_read;
      logic       mem_write;
      logic       adr_src;
      logic       reg_write;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] result_src;
      logic       fetch;
      logic       branch;
   } ctrl_word_t;

   function automatic logic is_legal_op(input logic [6:0] op);
      return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ);
   endfunction

endpackage

// File: rtl/multicycle_out_decode.sv
// Pure state-to-control-word decode; unlisted fields and unused states are 0.
module multicycle_out_decode
   import multicycle_pkg::*;
(
   input  logic [3:0] state,
   output ctrl_word_t cw
);

   always_comb begin
      cw = '0;
      case (state)
         S_FETCH: begin
            cw.mem_read   = 1'b1;
            cw.alu_src_a  = SRCA_PC;
            cw.alu_src_b  = SRCB_FOUR;
            cw.alu_op     = ALUOP_ADD;
            cw.result_src = RES_ALU;
            cw.fetch      = 1'b1;
         end
         S_DECODE: begin
            cw.alu_src_a = SRCA_OLDPC;
            cw.alu_src_b = SRCB_IMM;
            cw.alu_op    = ALUOP_ADD;
         end
         S_MEM_ADDR: begin
            cw.alu_src_a = SRCA_RS1;
            cw.alu_src_b = SRCB_IMM;
            cw.alu_op    = ALUOP_ADD;
         end
         S_MEM_READ: begin
            cw.mem_read = 1'b1;
            cw.adr_src  = 1'b1;
         end
         S_MEM_WB: begin
            cw.result_src = RES_DATA;
            cw.reg_write  = 1'b1;
         end
         S_MEM_WRITE: begin
            cw.mem_write = 1'b1;
            cw.adr_src   = 1'b1;
         end
         S_EXEC_R: begin
            cw.alu_src_a = SRCA_RS1;
            cw.alu_src_b = SRCB_RS2;
            cw.alu_op    = ALUOP_FUNCT;
         end
         S_ALU_WB: begin
            cw.result_src = RES_ALUOUT;
            cw.reg_write  = 1'b1;
         end
         S_BRANCH: begin
            cw.alu_src_a  = SRCA_RS1;
            cw.alu_src_b  = SRCB_RS2;
            cw.alu_op     = ALUOP_SUB;
            cw.result_src = RES_ALUOUT;
            cw.branch     = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle RV32 core (R-type, lw, sw, beq).
// state | meaning
// 0 FETCH     | read instruction at PC, PC += 4 on mem_ready
// 1 DECODE    | branch target into ALUOut, dispatch on opcode
// 2 MEM_ADDR  | rs1 + imm effective address
// 3 MEM_READ  | load data, stall until mem_ready
// 4 MEM_WB    | write load data to rd
// 5 MEM_WRITE | store data, stall until mem_ready
// 6 EXEC_R    | rs1 op rs2
// 7 ALU_WB    | write ALUOut to rd
// 8 BRANCH    | compare, take target when zero
module multicycle_ctrl
   import multicycle_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             mem_read,
   output logic             mem_write,
   output logic             adr_src,
   output logic             ir_write,
   output logic             pc_write,
   output logic             reg_write,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       ALUOp,
   output logic [1:0]       result_src,
   output logic             illegal,
   output logic [3:0]       state_dbg,
   output logic [CNT_W-1:0] retired
);

   logic [3:0] state;
   logic [3:0] state_nxt;
   logic       retire;
   ctrl_word_t cw;

   multicycle_out_decode u_out_decode (
      .state (state),
      .cw    (cw)
   );

   always_comb begin
      state_nxt = S_FETCH;
      case (state)
         S_FETCH:     state_nxt = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            if ((opcode == OP_LW) || (opcode == OP_SW)) state_nxt = S_MEM_ADDR;
            else if (opcode == OP_R)                    state_nxt = S_EXEC_R;
            else if (opcode == OP_BEQ)                  state_nxt = S_BRANCH;
            else                                        state_nxt = S_FETCH;
         end
         S_MEM_ADDR:  state_nxt = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ:  state_nxt = mem_ready ? S_MEM_WB : S_MEM_READ;
         S_MEM_WB:    state_nxt = S_FETCH;
         S_MEM_WRITE: state_nxt = mem_ready ? S_FETCH : S_MEM_WRITE;
         S_EXEC_R:    state_nxt = S_ALU_WB;
         S_ALU_WB:    state_nxt = S_FETCH;
         S_BRANCH:    state_nxt = S_FETCH;
         default:     state_nxt = S_FETCH;
      endcase
   end

   // an instruction retires on its last transition back to FETCH
   assign retire = (state == S_MEM_WB) || (state == S_ALU_WB) || (state == S_BRANCH) ||
                   ((state == S_MEM_WRITE) && mem_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_FETCH;
         retired <= '0;
      end else begin
         state <= state_nxt;
         if (retire) retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign mem_read   = cw.mem_read;
   assign mem_write  = cw.mem_write;
   assign adr_src    = cw.adr_src;
   assign reg_write  = cw.reg_write;
   assign alu_src_a  = cw.alu_src_a;
   assign alu_src_b  = cw.alu_src_b;
   assign ALUOp      = cw.alu_op;
   assign result_src = cw.result_src;
   assign ir_write   = cw.fetch & mem_ready;
   assign pc_write   = (cw.fetch & mem_ready) | (cw.branch & zero);
   assign illegal    = (state == S_DECODE) && !is_legal_op(opcode);
   assign state_dbg  = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl; a second CNT_W=2 instance shares all
// inputs so its counter shows the wrap behaviour.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] opcode;
   logic       zero;
   logic       mem_ready;

   logic        mem_read, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
   logic [1:0]  alu_src_a, alu_src_b, ALUOp, result_src;
   logic [3:0]  state_dbg;
   logic [31:0] retired;

   logic        w_mem_read, w_mem_write, w_adr_src, w_ir_write, w_pc_write, w_reg_write, w_illegal;
   logic [1:0]  w_alu_src_a, w_alu_src_b, w_ALUOp, w_result_src;
   logic [3:0]  w_state_dbg;
   logic [1:0]  w_retired;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   multicycle_ctrl #(.CNT_W(32)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .mem_read(mem_read), .mem_write(mem_write), .adr_src(adr_src),
      .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ALUOp(ALUOp),
      .result_src(result_src), .illegal(illegal), .state_dbg(state_dbg),
      .retired(retired)
   );

   multicycle_ctrl #(.CNT_W(2)) dut_w (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .mem_read(w_mem_read), .mem_write(w_mem_write), .adr_src(w_adr_src),
      .ir_write(w_ir_write), .pc_write(w_pc_write), .reg_write(w_reg_write),
      .alu_src_a(w_alu_src_a), .alu_src_b(w_alu_src_b), .ALUOp(w_ALUOp),
      .result_src(w_result_src), .illegal(w_illegal), .state_dbg(w_state_dbg),
      .retired(w_retired)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance one cycle; inputs and checks happen 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; opcode = 7'd0; zero = 1'b0; mem_ready = 1'b0;
      step();
      step();
      chk("rst_state", state_dbg, 0);
      chk("rst_retired", retired, 0);
      chk("rst_mem_read", mem_read, 1);
      chk("rst_alu_src_b", alu_src_b, 2);
      chk("rst_result_src", result_src, 2);
      chk("rst_ir_write", ir_write, 0);
      chk("rst_pc_write", pc_write, 0);

      // R-type: 0,1,6,7,0
      rst = 1'b0; mem_ready = 1'b1; opcode = 7'b0110011;
      #1;
      chk("r_fetch_ir_write", ir_write, 1);
      chk("r_fetch_pc_write", pc_write, 1);
      step();
      chk("r_decode_state", state_dbg, 1);
      chk("r_decode_src_a", alu_src_a, 1);
      chk("r_decode_src_b", alu_src_b, 1);
      chk("r_decode_ir_write", ir_write, 0);
      step();
      chk("r_exec_state", state_dbg, 6);
      chk("r_exec_aluop", ALUOp, 2);
      chk("r_exec_reg_write", reg_write, 0);
      chk("r_exec_src_a", alu_src_a, 2);
      step();
      chk("r_wb_state", state_dbg, 7);
      chk("r_wb_reg_write", reg_write, 1);
      chk("r_wb_result_src", result_src, 0);
      step();
      chk("r_done_state", state_dbg, 0);
      chk("r_retired", retired, 1);

      // lw with three stall cycles in MEM_READ
      opcode = 7'b0000011;
      step();
      chk("lw_decode_state", state_dbg, 1);
      step();
      chk("lw_addr_state", state_dbg, 2);
      chk("lw_addr_src_b", alu_src_b, 1);
      mem_ready = 1'b0;
      step();
      for (int i = 0; i < 4; i++) begin
         chk("lw_rd_state", state_dbg, 3);
         chk("lw_rd_mem_read", mem_read, 1);
         chk("lw_rd_adr_src", adr_src, 1);
         chk("lw_rd_ir_write", ir_write, 0);
         if (i == 3) mem_ready = 1'b1;
         step();
      end
      chk("lw_wb_state", state_dbg, 4);
      chk("lw_wb_result_src", result_src, 1);
      chk("lw_wb_reg_write", reg_write, 1);
      chk("lw_wb_retired", retired, 1);
      step();
      chk("lw_done_state", state_dbg, 0);
      chk("lw_retired", retired, 2);

      // sw: 0,1,2,5,0
      opcode = 7'b0100011;
      step();
      chk("sw_decode_state", state_dbg, 1);
      chk("sw_decode_mem_write", mem_write, 0);
      step();
      chk("sw_addr_state", state_dbg, 2);
      chk("sw_addr_mem_write", mem_write, 0);
      step();
      chk("sw_wr_state", state_dbg, 5);
      chk("sw_wr_mem_write", mem_write, 1);
      chk("sw_wr_adr_src", adr_src, 1);
      chk("sw_wr_reg_write", reg_write, 0);
      step();
      chk("sw_done_state", state_dbg, 0);
      chk("sw_done_mem_write", mem_write, 0);
      chk("sw_retired", retired, 3);

      // beq taken then not taken
      opcode = 7'b1100011; zero = 1'b1;
      step();
      step();
      chk("beq1_state", state_dbg, 8);
      chk("beq1_aluop", ALUOp, 1);
      chk("beq1_pc_write", pc_write, 1);
      step();
      chk("beq1_done_state", state_dbg, 0);
      chk("beq1_retired", retired, 4);
      zero = 1'b0;
      step();
      step();
      chk("beq0_state", state_dbg, 8);
      chk("beq0_pc_write", pc_write, 0);
      step();
      chk("beq0_retired", retired, 5);

      // illegal opcode
      opcode = 7'b1111111;
      chk("ill_fetch_illegal", illegal, 0);
      step();
      chk("ill_decode_state", state_dbg, 1);
      chk("ill_decode_illegal", illegal, 1);
      step();
      chk("ill_next_state", state_dbg, 0);
      chk("ill_next_illegal", illegal, 0);
      chk("ill_retired", retired, 5);

      // reset during a MEM_WRITE stall
      opcode = 7'b0100011;
      step();
      step();
      mem_ready = 1'b0;
      step();
      chk("stall_state", state_dbg, 5);
      step();
      chk("stall_hold_state", state_dbg, 5);
      chk("stall_mem_write", mem_write, 1);
      chk("stall_retired", retired, 5);
      rst = 1'b1;
      step();
      chk("stall_rst_state", state_dbg, 0);
      chk("stall_rst_mem_write", mem_write, 0);
      chk("stall_rst_retired", retired, 0);
      chk("stall_rst_w_retired", w_retired, 0);

      // five R-type retires: narrow counter wraps to 1
      rst = 1'b0; mem_ready = 1'b1; opcode = 7'b0110011;
      for (int n = 0; n < 5; n++) begin
         for (int c = 0; c < 4; c++) step();
      end
      chk("wrap_state", state_dbg, 0);
      chk("wrap_retired32", retired, 5);
      chk("wrap_retired2", w_retired, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
